multicycle_main_control: RTL and testbench
==========================================

// Module: multicycle_main_control
// PURPOSE
//  Main control FSM of the multicycle RV32 core. Decodes opcode/funct3/funct7b5 from IR and
//  sequences datapath mux selects, write enables and the 2-bit ALUOp consumed by the ALU
//  control decoder. Owns the memory request handshake, a retired-instruction counter and
//  a sticky illegal-instruction flag. Subset: lw, sw, add/sub/and/or, addi, beq.
// PARAMETERS
//  CNT_W   32   width of instret_o; wraps modulo 2^CNT_W
// PORTS
//  clk           in   1      core clock, all state on rising edge
//  rst_n         in   1      asynchronous, active-low reset
//  op_i          in   7      IR[6:0]
//  funct3_i      in   3      IR[14:12]
//  funct7b5_i    in   1      IR[30]
//  zero_i        in   1      ALU zero flag (current cycle)
//  mem_ready_i   in   1      memory completes access this cycle
//  mem_req_o     out  1      memory access request
//  mem_write_o   out  1      request is a store
//  adr_src_o     out  1      0=PC, 1=ALUOut as memory address
//  ir_write_o    out  1      load IR and OldPC
//  pc_write_o    out  1      = pc_update | (branch & zero_i)
//  reg_write_o   out  1      register file write
//  result_src_o  out  2      00=ALUOut 01=MemData 10=ALUResult
//  alu_src_a_o   out  2      00=PC 01=OldPC 10=rs1
//  alu_src_b_o   out  2      00=rs2 01=ImmExt 10=const 4
//  alu_op_o      out  2      00=add 01=sub 10=funct decode
//  illegal_o     out  1      sticky: unsupported instruction seen
//  instret_o     out  CNT_W  retired instruction count
// BEHAVIOUR
//  - Moore outputs decoded from state; pc_write_o, ir_write_o gated by mem_ready_i in FETCH.
//  - Reset (async, rst_n=0): state=RESET, instret_o=0, illegal_o=0; all outputs 0.
//  - RESET: all outputs 0 -> FETCH next cycle (no IR/PC write during/just after reset).
//  - FETCH: mem_req=1, adr_src=0, srcA=00, srcB=10, alu_op=00, result_src=10. Hold until
//    mem_ready_i; in the ready cycle only: ir_write=1, pc_write=1 -> DECODE. Exactly one PC+4.
//  - DECODE: srcA=01, srcB=01, alu_op=00 (branch target into ALUOut). Next state:
//    0000011/0100011 -> MEMADR; 0110011 with {f7b5,f3} in {0_000,1_000,0_111,0_110} -> EXECR;
//    0010011 with f3=000 -> EXECI; 1100011 with f3=000 -> BEQ; anything else -> ILLEGAL.
//  - MEMADR: srcA=10, srcB=01, alu_op=00 -> MEMREAD (lw) or MEMWRITE (sw).
//  - MEMREAD: mem_req=1, adr_src=1; hold until ready -> MEMWB.
//  - MEMWB: result_src=01, reg_write=1 -> FETCH (retire).
//  - MEMWRITE: mem_req=1, mem_write=1, adr_src=1; hold until ready -> FETCH (retire).
//  - EXECR: srcA=10, srcB=00, alu_op=10 -> ALUWB. EXECI: srcA=10, srcB=01, alu_op=00 -> ALUWB.
//  - ALUWB: result_src=00, reg_write=1 -> FETCH (retire).
//  - BEQ: srcA=10, srcB=00, alu_op=01, result_src=00, branch=1 -> FETCH (retire);
//    pc_write_o=zero_i (taken loads ALUOut target).
//  - ILLEGAL: absorbing until reset; all enables/requests 0, illegal_o=1 from entry cycle.
//  - instret_o += 1 on every retiring transition into FETCH; wraps all-ones -> 0 silently.
//  - mem_req_o held high and address/write selects stable until mem_ready_i; mem_ready_i
//    outside a requesting state is ignored. Latency: lw 5+waits, sw 4+waits, R/I 4, beq 3.
//  - Reset mid-access: request drops asynchronously; no retire counted.
//  - IR inputs only sampled in DECODE/MEMADR; values in other states are don't-care.
// STRUCTURE
//  - Package riscv_ctrl_pkg: opcode localparams, ALUOp codes (ADD/SUB/FUNCT), result/srcA/srcB
//    select encodings, state_t enum (RESET..ILLEGAL); shared with ALU control and datapath.
//  - One sub-module: ctrl_instr_legal (combinational legality check of op/funct3/funct7b5).
//  - Single state register + next-state logic + output decode + instret/illegal flops.
// TESTING
//  - Reset release, mem_ready=1: cycle1 all outputs 0; cycle2 FETCH, ir_write=pc_write=1.
//  - add (op=0110011,f3=000,f7b5=0), ready=1: FETCH,DECODE,EXECR(alu_op=10),ALUWB
//    (reg_write=1); instret 0->1.
//  - lw with mem_ready low 3 cycles in FETCH and MEMREAD: mem_req held, single pc_write,
//    MEMWB result_src=01; sw: mem_write=1 only in MEMWRITE, no reg_write.
//  - beq zero_i=1 -> pc_write=1 in BEQ with alu_op=01; zero_i=0 -> pc_write=0; both retire.
//  - op=1111111 or R-type {1,111}: DECODE -> ILLEGAL, illegal_o=1, no further req; reset clears.
//  - CNT_W=4, 16 addi retired: instret 15 -> 0; rst_n low mid-MEMREAD: req=0 same cycle.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32 control path: opcodes, ALUOp codes,
// datapath select encodings, control FSM states and the decoded control word.
package riscv_ctrl_pkg;

    localparam int unsigned OP_W  = 7;
    localparam int unsigned F3_W  = 3;
    localparam int unsigned SEL_W = 2;

    // Supported major opcodes (IR[6:0])
    localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;

    // funct3 values of the supported subset
    localparam logic [F3_W-1:0] F3_ADD = 3'b000;
    localparam logic [F3_W-1:0] F3_AND = 3'b111;
    localparam logic [F3_W-1:0] F3_OR  = 3'b110;
    localparam logic [F3_W-1:0] F3_BEQ = 3'b000;

    // ALUOp handed to the ALU control decoder
    localparam logic [SEL_W-1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [SEL_W-1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [SEL_W-1:0] ALU_OP_FUNCT = 2'b10;

    // Result mux select
    localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
    localparam logic [SEL_W-1:0] RES_MEMDATA   = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

    // ALU source A select
    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;

    // ALU source B select
    localparam logic [SEL_W-1:0] SRCB_RS2  = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

    typedef enum logic [3:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BEQ,
        S_ILLEGAL
    } state_t;

    // Instruction class produced by the legality checker
    typedef enum logic [2:0] {
        IK_MEM,
        IK_RTYPE,
        IK_ITYPE,
        IK_BRANCH,
        IK_NONE
    } instr_kind_t;

    // Control word driven onto the datapath each cycle
    typedef struct packed {
        logic             mem_req;
        logic             mem_write;
        logic             adr_src;
        logic             ir_write;
        logic             pc_write;
        logic             reg_write;
        logic [SEL_W-1:0] result_src;
        logic [SEL_W-1:0] alu_src_a;
        logic [SEL_W-1:0] alu_src_b;
        logic [SEL_W-1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/ctrl_instr_legal.sv
// Combinational legality check / classification of an instruction.
// Ports:
//   op_i, funct3_i, funct7b5_i : instruction fields from IR
//   kind_o                     : instruction class (IK_NONE when unsupported)
//   legal_o                    : 1 when the instruction is in the supported subset
module ctrl_instr_legal
    import riscv_ctrl_pkg::*;
(
    input  logic [OP_W-1:0] op_i,
    input  logic [F3_W-1:0] funct3_i,
    input  logic            funct7b5_i,
    output instr_kind_t     kind_o,
    output logic            legal_o
);

    // add/sub share funct3=000; and/or require funct7b5=0
    always_comb begin
        kind_o = IK_NONE;
        case (op_i)
            OP_LOAD, OP_STORE: kind_o = IK_MEM;
            OP_RTYPE: begin
                if ((funct3_i == F3_ADD) ||
                    (!funct7b5_i && ((funct3_i == F3_AND) || (funct3_i == F3_OR)))) begin
                    kind_o = IK_RTYPE;
                end
            end
            OP_ITYPE: begin
                if (funct3_i == F3_ADD) kind_o = IK_ITYPE;
            end
            OP_BRANCH: begin
                if (funct3_i == F3_BEQ) kind_o = IK_BRANCH;
            end
            default: kind_o = IK_NONE;
        endcase
    end

    assign legal_o = (kind_o != IK_NONE);

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM of the multicycle RV32 core (lw, sw, add/sub/and/or, addi, beq).
// Ports:
//   clk, rst_n                      : clock, async active-low reset
//   op_i, funct3_i, funct7b5_i      : instruction fields from IR
//   zero_i                          : ALU zero flag
//   mem_ready_i                     : memory completes the current access
//   mem_req_o, mem_write_o, adr_src_o, ir_write_o, pc_write_o, reg_write_o,
//   result_src_o, alu_src_a_o, alu_src_b_o, alu_op_o : datapath control (state-decoded)
//   illegal_o                       : sticky unsupported-instruction flag
//   instret_o                       : retired instruction count, wraps
module multicycle_main_control
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OP_W-1:0]  op_i,
    input  logic [F3_W-1:0]  funct3_i,
    input  logic             funct7b5_i,
    input  logic             zero_i,
    input  logic             mem_ready_i,
    output logic             mem_req_o,
    output logic             mem_write_o,
    output logic             adr_src_o,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic             reg_write_o,
    output logic [SEL_W-1:0] result_src_o,
    output logic [SEL_W-1:0] alu_src_a_o,
    output logic [SEL_W-1:0] alu_src_b_o,
    output logic [SEL_W-1:0] alu_op_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] instret_o
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             illegal_q, illegal_d;
    logic             retire_c;
    instr_kind_t      kind_c;
    logic             legal_c;
    ctrl_t            ctrl_c;

    ctrl_instr_legal u_instr_legal (
        .op_i       (op_i),
        .funct3_i   (funct3_i),
        .funct7b5_i (funct7b5_i),
        .kind_o     (kind_c),
        .legal_o    (legal_c)
    );

    // State, retire counter and sticky illegal flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RESET;
            instret_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
        end
    end

    // Next state and control word; outputs follow the current state
    always_comb begin
        state_d  = state_q;
        retire_c = 1'b0;
        ctrl_c   = '0;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                ctrl_c.mem_req    = 1'b1;
                ctrl_c.alu_src_a  = SRCA_PC;
                ctrl_c.alu_src_b  = SRCB_FOUR;
                ctrl_c.alu_op     = ALU_OP_ADD;
                ctrl_c.result_src = RES_ALURESULT;
                // IR load and PC+4 only in the cycle the fetch completes
                ctrl_c.ir_write   = mem_ready_i;
                ctrl_c.pc_write   = mem_ready_i;
                if (mem_ready_i) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Branch target PC+imm is parked in ALUOut here
                ctrl_c.alu_src_a = SRCA_OLDPC;
                ctrl_c.alu_src_b = SRCB_IMM;
                ctrl_c.alu_op    = ALU_OP_ADD;
                case (kind_c)
                    IK_MEM:    state_d = S_MEMADR;
                    IK_RTYPE:  state_d = S_EXECR;
                    IK_ITYPE:  state_d = S_EXECI;
                    IK_BRANCH: state_d = S_BEQ;
                    default:   state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                ctrl_c.alu_src_a = SRCA_RS1;
                ctrl_c.alu_src_b = SRCB_IMM;
                ctrl_c.alu_op    = ALU_OP_ADD;
                state_d = (op_i == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                ctrl_c.mem_req = 1'b1;
                ctrl_c.adr_src = 1'b1;
                if (mem_ready_i) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ctrl_c.result_src = RES_MEMDATA;
                ctrl_c.reg_write  = 1'b1;
                retire_c          = 1'b1;
                state_d           = S_FETCH;
            end
            S_MEMWRITE: begin
                ctrl_c.mem_req   = 1'b1;
                ctrl_c.mem_write = 1'b1;
                ctrl_c.adr_src   = 1'b1;
                if (mem_ready_i) begin
                    retire_c = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_EXECR: begin
                ctrl_c.alu_src_a = SRCA_RS1;
                ctrl_c.alu_src_b = SRCB_RS2;
                ctrl_c.alu_op    = ALU_OP_FUNCT;
                state_d          = S_ALUWB;
            end
            S_EXECI: begin
                ctrl_c.alu_src_a = SRCA_RS1;
                ctrl_c.alu_src_b = SRCB_IMM;
                ctrl_c.alu_op    = ALU_OP_ADD;
                state_d          = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl_c.result_src = RES_ALUOUT;
                ctrl_c.reg_write  = 1'b1;
                retire_c          = 1'b1;
                state_d           = S_FETCH;
            end
            S_BEQ: begin
                ctrl_c.alu_src_a  = SRCA_RS1;
                ctrl_c.alu_src_b  = SRCB_RS2;
                ctrl_c.alu_op     = ALU_OP_SUB;
                ctrl_c.result_src = RES_ALUOUT;
                ctrl_c.pc_write   = zero_i;
                retire_c          = 1'b1;
                state_d           = S_FETCH;
            end
            S_ILLEGAL: state_d = S_ILLEGAL;
            default:   state_d = S_RESET;
        endcase
    end

    assign instret_d = retire_c ? instret_q + CNT_W'(1) : instret_q;
    assign illegal_d = illegal_q | ((state_q == S_DECODE) && !legal_c);

    assign mem_req_o    = ctrl_c.mem_req;
    assign mem_write_o  = ctrl_c.mem_write;
    assign adr_src_o    = ctrl_c.adr_src;
    assign ir_write_o   = ctrl_c.ir_write;
    assign pc_write_o   = ctrl_c.pc_write;
    assign reg_write_o  = ctrl_c.reg_write;
    assign result_src_o = ctrl_c.result_src;
    assign alu_src_a_o  = ctrl_c.alu_src_a;
    assign alu_src_b_o  = ctrl_c.alu_src_b;
    assign alu_op_o     = ctrl_c.alu_op;
    assign illegal_o    = illegal_q;
    assign instret_o    = instret_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Scoreboard bench for multicycle_main_control: an instruction-level model pushes the
// expected per-cycle control word and retire count; a negedge monitor pops and compares.
// A second instance with CNT_W=4 shares all inputs to exercise counter wrap.
module tb_multicycle_main_control;

    localparam logic [6:0] LW = 7'b0000011;
    localparam logic [6:0] SW = 7'b0100011;
    localparam logic [6:0] RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011;
    localparam logic [6:0] BR = 7'b1100011;

    localparam int C_LW = 0, C_SW = 1, C_R = 2, C_I = 3, C_B = 4, C_ILL = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, zero_i, mem_ready_i, funct7b5_i;
    logic [6:0] op_i;
    logic [2:0] funct3_i;

    logic        mem_req_a, mem_write_a, adr_src_a, ir_write_a, pc_write_a, reg_write_a, illegal_a;
    logic [1:0]  result_src_a, srca_a, srcb_a, alu_op_a;
    logic [31:0] instret_a;
    logic        mem_req_b, mem_write_b, adr_src_b, ir_write_b, pc_write_b, reg_write_b, illegal_b;
    logic [1:0]  result_src_b, srca_b, srcb_b, alu_op_b;
    logic [3:0]  instret_b;

    multicycle_main_control u_dut (
        .clk(clk), .rst_n(rst_n), .op_i(op_i), .funct3_i(funct3_i), .funct7b5_i(funct7b5_i),
        .zero_i(zero_i), .mem_ready_i(mem_ready_i),
        .mem_req_o(mem_req_a), .mem_write_o(mem_write_a), .adr_src_o(adr_src_a),
        .ir_write_o(ir_write_a), .pc_write_o(pc_write_a), .reg_write_o(reg_write_a),
        .result_src_o(result_src_a), .alu_src_a_o(srca_a), .alu_src_b_o(srcb_a),
        .alu_op_o(alu_op_a), .illegal_o(illegal_a), .instret_o(instret_a)
    );

    multicycle_main_control #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .op_i(op_i), .funct3_i(funct3_i), .funct7b5_i(funct7b5_i),
        .zero_i(zero_i), .mem_ready_i(mem_ready_i),
        .mem_req_o(mem_req_b), .mem_write_o(mem_write_b), .adr_src_o(adr_src_b),
        .ir_write_o(ir_write_b), .pc_write_o(pc_write_b), .reg_write_o(reg_write_b),
        .result_src_o(result_src_b), .alu_src_a_o(srca_b), .alu_src_b_o(srcb_b),
        .alu_op_o(alu_op_b), .illegal_o(illegal_b), .instret_o(instret_b)
    );

    wire [14:0] act_a = {mem_req_a, mem_write_a, adr_src_a, ir_write_a, pc_write_a, reg_write_a,
                         result_src_a, srca_a, srcb_a, alu_op_a, illegal_a};
    wire [14:0] act_b = {mem_req_b, mem_write_b, adr_src_b, ir_write_b, pc_write_b, reg_write_b,
                         result_src_b, srcb_dummy_fix(srca_b), srcb_b, alu_op_b, illegal_b};

    function automatic logic [1:0] srcb_dummy_fix(input logic [1:0] v);
        return v;
    endfunction

    typedef struct {
        logic [14:0] ctl;
        logic [31:0] cnt;
        string       tag;
    } exp_t;

    exp_t        sbq[$];
    exp_t        cur;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [31:0] model_cnt = '0;

    // Monitor: one expected entry per cycle, compared away from the rising edge
    always @(negedge clk) begin
        if (sbq.size() != 0) begin
            cur = sbq.pop_front();
            n_vec++;
            if ((act_a !== cur.ctl) || (instret_a !== cur.cnt) ||
                (act_b !== cur.ctl) || (instret_b !== cur.cnt[3:0])) begin
                n_err++;
                $display("FAIL %s @%0t: got ctl=%b instret=%0d ctl4=%b instret4=%0d, expected ctl=%b instret=%0d instret4=%0d",
                         cur.tag, $time, act_a, instret_a, act_b, instret_b, cur.ctl, cur.cnt, cur.cnt[3:0]);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Control word layout: req wr adr irw pcw rw res[2] srcA[2] srcB[2] aluop[2] ill
    function automatic logic [14:0] mk(input logic req, input logic wr, input logic adr,
                                       input logic irw, input logic pcw, input logic rw,
                                       input logic [1:0] rs, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [1:0] ao,
                                       input logic ill);
        return {req, wr, adr, irw, pcw, rw, rs, sa, sb, ao, ill};
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction
    function automatic logic [6:0] ro();
        return 7'($urandom);
    endfunction
    function automatic logic [2:0] rf();
        return 3'($urandom);
    endfunction

    // Supported subset from the instruction table
    function automatic int classify(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        if (op == LW) return C_LW;
        if (op == SW) return C_SW;
        if (op == RT && ({f7, f3} == 4'b0000 || {f7, f3} == 4'b1000 ||
                         {f7, f3} == 4'b0111 || {f7, f3} == 4'b0110)) return C_R;
        if (op == IT && f3 == 3'b000) return C_I;
        if (op == BR && f3 == 3'b000) return C_B;
        return C_ILL;
    endfunction

    // Drive one cycle's inputs and push that cycle's expected outputs
    task automatic cyc(input logic rn, input logic rdy, input logic z, input logic [6:0] op,
                       input logic [2:0] f3, input logic f7, input logic [14:0] ctl,
                       input string tag);
        @(posedge clk);
        #1;
        rst_n = rn; mem_ready_i = rdy; zero_i = z;
        op_i = op; funct3_i = f3; funct7b5_i = f7;
        sbq.push_back('{ctl: ctl, cnt: model_cnt, tag: tag});
    endtask

    task automatic do_reset();
        model_cnt = '0;
        cyc(1'b0, 1'b1, rb(), ro(), rf(), rb(), 15'd0, "reset_hold");
        cyc(1'b0, 1'b1, rb(), ro(), rf(), rb(), 15'd0, "reset_hold");
        cyc(1'b1, 1'b1, rb(), ro(), rf(), rb(), 15'd0, "reset_release");
    endtask

    task automatic fetch(input int waits);
        for (int i = 0; i < waits; i++)
            cyc(1'b1, 1'b0, rb(), ro(), rf(), rb(),
                mk(1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0), "fetch_wait");
        cyc(1'b1, 1'b1, rb(), ro(), rf(), rb(),
            mk(1, 0, 0, 1, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0), "fetch");
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic z, input int fw, input int mw, input bit abort);
        int k = classify(op, f3, f7);
        fetch(fw);
        cyc(1'b1, rb(), rb(), op, f3, f7,
            mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0), "decode");
        case (k)
            C_LW, C_SW: begin
                cyc(1'b1, rb(), rb(), op, f3, f7,
                    mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0), "memadr");
                if (k == C_LW) begin
                    for (int i = 0; i < mw; i++)
                        cyc(1'b1, 1'b0, rb(), ro(), rf(), rb(),
                            mk(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0), "memread_wait");
                    if (abort) begin
                        do_reset();
                        return;
                    end
                    cyc(1'b1, 1'b1, rb(), ro(), rf(), rb(),
                        mk(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0), "memread");
                    cyc(1'b1, rb(), rb(), ro(), rf(), rb(),
                        mk(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 0), "memwb");
                end else begin
                    for (int i = 0; i < mw; i++)
                        cyc(1'b1, 1'b0, rb(), ro(), rf(), rb(),
                            mk(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0), "memwrite_wait");
                    cyc(1'b1, 1'b1, rb(), ro(), rf(), rb(),
                        mk(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0), "memwrite");
                end
                model_cnt++;
            end
            C_R, C_I: begin
                if (k == C_R)
                    cyc(1'b1, rb(), rb(), ro(), rf(), rb(),
                        mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0), "execr");
                else
                    cyc(1'b1, rb(), rb(), ro(), rf(), rb(),
                        mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0), "execi");
                cyc(1'b1, rb(), rb(), ro(), rf(), rb(),
                    mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0), "aluwb");
                model_cnt++;
            end
            C_B: begin
                cyc(1'b1, rb(), z, ro(), rf(), rb(),
                    mk(0, 0, 0, 0, z, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0), "beq");
                model_cnt++;
            end
            default: begin
                for (int i = 0; i < 3; i++)
                    cyc(1'b1, rb(), rb(), ro(), rf(), rb(),
                        mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1), "illegal");
                do_reset();
            end
        endcase
    endtask

    initial begin
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        rst_n = 1'b0; mem_ready_i = 1'b1; zero_i = 1'b0;
        op_i = '0; funct3_i = '0; funct7b5_i = 1'b0;

        do_reset();
        run_instr(RT, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0);      // add
        run_instr(LW, rf(), rb(), 1'b0, 3, 3, 1'b0);        // lw with waits
        run_instr(SW, rf(), rb(), 1'b0, 1, 2, 1'b0);        // sw with waits
        run_instr(BR, 3'b000, rb(), 1'b1, 0, 0, 1'b0);      // beq taken
        run_instr(BR, 3'b000, rb(), 1'b0, 0, 0, 1'b0);      // beq not taken
        run_instr(RT, 3'b000, 1'b1, 1'b0, 0, 0, 1'b0);      // sub
        run_instr(RT, 3'b111, 1'b0, 1'b0, 0, 0, 1'b0);      // and
        run_instr(RT, 3'b110, 1'b0, 1'b0, 0, 0, 1'b0);      // or
        run_instr(IT, 3'b000, rb(), 1'b0, 0, 0, 1'b0);      // addi
        run_instr(7'b1111111, rf(), rb(), 1'b0, 0, 0, 1'b0); // bad opcode
        run_instr(RT, 3'b111, 1'b1, 1'b0, 0, 0, 1'b0);      // bad R-type funct
        run_instr(IT, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0);
        run_instr(LW, rf(), rb(), 1'b0, 0, 2, 1'b1);        // reset mid-MEMREAD
        for (int i = 0; i < 17; i++)                         // 4-bit counter wraps
            run_instr(IT, 3'b000, rb(), 1'b0, 0, 0, 1'b0);

        for (int n = 0; n < 150; n++) begin
            f3 = rf();
            f7 = rb();
            case ($urandom_range(0, 5))
                0: op = LW;
                1: op = SW;
                2: begin
                    op = RT;
                    if ($urandom_range(0, 3) != 0) begin
                        case ($urandom_range(0, 3))
                            0: {f7, f3} = 4'b0000;
                            1: {f7, f3} = 4'b1000;
                            2: {f7, f3} = 4'b0111;
                            default: {f7, f3} = 4'b0110;
                        endcase
                    end
                end
                3: begin op = IT; if ($urandom_range(0, 3) != 0) f3 = 3'b000; end
                4: begin op = BR; if ($urandom_range(0, 3) != 0) f3 = 3'b000; end
                default: op = ro();
            endcase
            run_instr(op, f3, f7, rb(), $urandom_range(0, 3), $urandom_range(0, 3),
                      ($urandom_range(0, 19) == 0));
        end

        @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
